// File: rtl/mc_bus_responder.sv
// MCU parallel-bus responder: synchronizes the async strobes, commits writes
// to the config bank or command FIFO, serves reads, and raises irq0/irq1.
module mc_bus_responder #(
  parameter logic [5:0] CFG_BASE    = 6'h18,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mc_ce,
  input  logic          mc_we,
  input  logic          mc_oe,
  input  logic [5:0]    mc_add,
  inout  wire  [15:0]   mc_data,
  output logic [127:0]  cfg_regs,
  output logic [15:0]   cmd_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  input  logic [15:0]   res_data,
  input  logic          res_empty,
  output logic          res_pop,
  output logic          irq0,
  output logic          irq1
);

  logic [SYNC_STAGES-1:0] ce_sync, we_sync, oe_sync, vld_sync;
  logic ce_s, we_s, oe_s, vld;
  logic we_arm, oe_arm;
  logic we_low, oe_low, we_low_q, oe_low_q;
  logic we_act, oe_act, bus_err;
  logic we_rise, we_end, oe_fall, oe_rise, oe_end;
  logic [5:0]  wr_add;
  logic [15:0] wr_data;
  logic        wr_pend;
  logic [5:0]  wr_idx, rd_idx;
  logic        commit, commit_cmd, commit_cfg;
  logic [7:0][15:0] cfg_q;
  logic [15:0] rd_reg, rd_word;
  logic        pop_pend, stat_pend;
  logic        overflow, underflow;
  logic        set_ovf, set_udf, clr_flags;
  logic        drive_en;

  assign ce_s = ce_sync[SYNC_STAGES-1];
  assign we_s = we_sync[SYNC_STAGES-1];
  assign oe_s = oe_sync[SYNC_STAGES-1];
  assign vld  = vld_sync[SYNC_STAGES-1];

  // Strobe synchronizers; vld_sync marks when the chain holds real post-reset samples.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ce_sync  <= '1;
      we_sync  <= '1;
      oe_sync  <= '1;
      vld_sync <= '0;
    end else begin
      ce_sync  <= {ce_sync[SYNC_STAGES-2:0], mc_ce};
      we_sync  <= {we_sync[SYNC_STAGES-2:0], mc_we};
      oe_sync  <= {oe_sync[SYNC_STAGES-2:0], mc_oe};
      vld_sync <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // A strobe only counts once it has been seen high after reset, so a strobe
  // held low across reset release cannot produce an edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      we_arm   <= 1'b0;
      oe_arm   <= 1'b0;
      we_low_q <= 1'b0;
      oe_low_q <= 1'b0;
    end else begin
      we_arm   <= we_arm | (vld & we_s);
      oe_arm   <= oe_arm | (vld & oe_s);
      we_low_q <= we_low;
      oe_low_q <= oe_low;
    end
  end

  // Strobe qualification and edge decode.
  always_comb begin
    we_low  = we_arm & ~we_s;
    oe_low  = oe_arm & ~oe_s;
    we_act  = we_low & ~ce_s;
    oe_act  = oe_low & ~ce_s;
    bus_err = we_act & oe_act;
    we_end  = we_low_q & ~we_low;
    oe_end  = oe_low_q & ~oe_low;
    we_rise = we_end & ~ce_s;
    oe_rise = oe_end & ~ce_s;
    oe_fall = oe_low & ~oe_low_q & ~ce_s & ~we_act;
  end

  // Write commit decode; wr_idx wraps below CFG_BASE so one compare covers the bank.
  always_comb begin
    wr_idx     = wr_add - CFG_BASE;
    rd_idx     = mc_add - CFG_BASE;
    commit     = we_rise & wr_pend & ~oe_act;
    commit_cmd = commit & (wr_add == 6'd0);
    commit_cfg = commit & (wr_idx < 6'd8);
  end

  // Latch address/data during a clean write strobe; a bus error or any
  // strobe release discards the pending write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_add  <= '0;
      wr_data <= '0;
      wr_pend <= 1'b0;
    end else if (bus_err) begin
      wr_pend <= 1'b0;
    end else if (we_act) begin
      wr_add  <= mc_add;
      wr_data <= mc_data;
      wr_pend <= 1'b1;
    end else if (we_end) begin
      wr_pend <= 1'b0;
    end
  end

  // Config bank update on commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cfg_q <= '0;
    end else if (commit_cfg) begin
      cfg_q[wr_idx[2:0]] <= wr_data;
    end
  end

  assign cfg_regs = cfg_q;

  // Command FIFO push; the word is dropped when the FIFO is not ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= commit_cmd & cmd_ready;
      if (commit_cmd) cmd_data <= wr_data;
    end
  end

  // Read word selection from the address map.
  always_comb begin
    rd_word = 16'h0000;
    if (mc_add == 6'd0)       rd_word = res_empty ? 16'h0000 : res_data;
    else if (mc_add == 6'd1)  rd_word = {12'h000, underflow, overflow, cmd_ready, res_empty};
    else if (rd_idx < 6'd8)   rd_word = cfg_q[rd_idx[2:0]];
  end

  // Read capture on strobe assert, pop/clear bookkeeping on strobe release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_reg    <= '0;
      pop_pend  <= 1'b0;
      stat_pend <= 1'b0;
      res_pop   <= 1'b0;
    end else begin
      res_pop <= oe_rise & pop_pend;
      if (oe_fall) begin
        rd_reg    <= rd_word;
        pop_pend  <= (mc_add == 6'd0) & ~res_empty;
        stat_pend <= (mc_add == 6'd1);
      end else if (oe_end) begin
        pop_pend  <= 1'b0;
        stat_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    set_ovf   = commit_cmd & ~cmd_ready;
    set_udf   = oe_fall & (mc_add == 6'd0) & res_empty;
    clr_flags = oe_rise & stat_pend;
  end

  // Sticky error flags; a set in the clearing cycle wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= set_ovf | (overflow & ~clr_flags);
      underflow <= set_udf | (underflow & ~clr_flags);
    end
  end

  // Registered interrupt outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq0 <= 1'b0;
      irq1 <= 1'b0;
    end else begin
      irq0 <= ~res_empty;
      irq1 <= overflow | underflow;
    end
  end

  assign drive_en = oe_act & ~we_act;
  assign mc_data  = drive_en ? rd_reg : 16'hzzzz;

endmodule

// File: tb/tb_mc_bus_responder.sv
// Randomized bench for mc_bus_responder against a transaction-level model.
module tb_mc_bus_responder;

  logic         clock;
  logic         reset;
  logic         mc_ce, mc_we, mc_oe;
  logic [5:0]   mc_add;
  tri1  [15:0]  mc_data;
  logic [127:0] cfg_regs;
  logic [15:0]  cmd_data;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [15:0]  res_data;
  logic         res_empty;
  logic         res_pop;
  logic         irq0, irq1;

  logic         drv_en;
  logic [15:0]  drv_data;

  assign mc_data = drv_en ? drv_data : 16'hzzzz;

  mc_bus_responder dut (
    .clock     (clock),
    .reset     (reset),
    .mc_ce     (mc_ce),
    .mc_we     (mc_we),
    .mc_oe     (mc_oe),
    .mc_add    (mc_add),
    .mc_data   (mc_data),
    .cfg_regs  (cfg_regs),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .res_data  (res_data),
    .res_empty (res_empty),
    .res_pop   (res_pop),
    .irq0      (irq0),
    .irq1      (irq1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_vec = 0;
  int n_err = 0;

  // observed pushes and pops
  logic [15:0] cmd_seen [$];
  int          pop_cnt = 0;

  always @(negedge clock) begin
    if (cmd_valid) cmd_seen.push_back(cmd_data);
    if (res_pop) pop_cnt++;
  end

  // reference model state
  logic [15:0] cfg_m [8];
  logic [15:0] exp_cmd [$];
  logic [15:0] exp_cmd_data;
  logic        ovf_m, udf_m;
  int          exp_pops = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] cfg_packed();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = cfg_m[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) cfg_m[i] = 16'h0000;
    ovf_m        = 1'b0;
    udf_m        = 1'b0;
    exp_cmd_data = 16'h0000;
  endfunction

  function automatic bit in_cfg(input logic [5:0] a);
    return (a >= 6'h18) && (a <= 6'h1F);
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [15:0] d);
    if (a == 6'h00) begin
      exp_cmd_data = d;
      if (cmd_ready) exp_cmd.push_back(d);
      else ovf_m = 1'b1;
    end else if (in_cfg(a)) begin
      cfg_m[int'(a) - 24] = d;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [5:0] a);
    logic [15:0] v;
    v = 16'h0000;
    if (a == 6'h00) begin
      if (res_empty) udf_m = 1'b1;
      else begin
        v = res_data;
        exp_pops++;
      end
    end else if (a == 6'h01) begin
      v = {12'h000, udf_m, ovf_m, cmd_ready, res_empty};
      udf_m = 1'b0;
      ovf_m = 1'b0;
    end else if (in_cfg(a)) begin
      v = cfg_m[int'(a) - 24];
    end
    return v;
  endfunction

  task automatic post_checks(input string tag);
    check_val({tag, "_cfg"}, cfg_regs, cfg_packed());
    check_val({tag, "_ncmd"}, 128'(cmd_seen.size()), 128'(exp_cmd.size()));
    if (cmd_seen.size() == exp_cmd.size() && exp_cmd.size() > 0)
      check_val({tag, "_cmdq"}, 128'(cmd_seen[$]), 128'(exp_cmd[$]));
    check_val({tag, "_cmd_data"}, 128'(cmd_data), 128'(exp_cmd_data));
    check_val({tag, "_npop"}, 128'(pop_cnt), 128'(exp_pops));
    check_val({tag, "_irq1"}, 128'(irq1), 128'(ovf_m | udf_m));
    check_val({tag, "_irq0"}, 128'(irq0), 128'(!res_empty));
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    mc_add = a; drv_data = d; drv_en = 1'b1; mc_ce = 1'b0;
    @(negedge clock);
    mc_we = 1'b0;
    repeat (6) @(negedge clock);
    mc_we = 1'b1;
    repeat (3) @(negedge clock);
    drv_en = 1'b0; mc_ce = 1'b1;
    repeat (5) @(negedge clock);
    model_write(a, d);
    post_checks("wr");
  endtask

  task automatic bus_read(input logic [5:0] a);
    logic [15:0] expv;
    expv = model_read(a);
    @(negedge clock);
    mc_add = a; mc_ce = 1'b0;
    @(negedge clock);
    mc_oe = 1'b0;
    repeat (5) @(negedge clock);
    check_val("rd_data", 128'(mc_data), 128'(expv));
    @(negedge clock);
    mc_oe = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rd_release", 128'(mc_data), 128'(16'hFFFF));
    repeat (3) @(negedge clock);
    mc_ce = 1'b1;
    repeat (3) @(negedge clock);
    post_checks("rd");
  endtask

  task automatic bus_error_cycle();
    @(negedge clock);
    mc_add = 6'h00; drv_en = 1'b0; mc_ce = 1'b0; cmd_ready = 1'b1; res_empty = 1'b0;
    @(negedge clock);
    mc_we = 1'b0; mc_oe = 1'b0;
    repeat (5) @(negedge clock);
    check_val("err_nodrive", 128'(mc_data), 128'(16'hFFFF));
    mc_we = 1'b1; mc_oe = 1'b1;
    repeat (6) @(negedge clock);
    mc_ce = 1'b1;
    repeat (3) @(negedge clock);
    post_checks("err");
  endtask

  task automatic reset_mid_write();
    @(negedge clock);
    mc_add = 6'h1A; drv_data = 16'h00FF; drv_en = 1'b1; mc_ce = 1'b0;
    @(negedge clock);
    mc_we = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    mc_we = 1'b1;
    repeat (3) @(negedge clock);
    drv_en = 1'b0; mc_ce = 1'b1;
    repeat (5) @(negedge clock);
    model_reset();
    check_val("rst_reg1a", 128'(cfg_regs[47:32]), 128'(16'h0000));
    post_checks("rst");
  endtask

  logic [5:0]  r_add;
  logic [15:0] r_dat;

  initial begin
    reset = 1'b0; mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1; mc_add = 6'h00;
    drv_en = 1'b0; drv_data = 16'h0000;
    cmd_ready = 1'b1; res_empty = 1'b0; res_data = 16'h0000;
    model_reset();
    repeat (3) @(negedge clock);
    check_val("rst_cfg", cfg_regs, 128'h0);
    check_val("rst_cmd_valid", 128'(cmd_valid), 128'h0);
    check_val("rst_res_pop", 128'(res_pop), 128'h0);
    check_val("rst_irq0", 128'(irq0), 128'h0);
    check_val("rst_irq1", 128'(irq1), 128'h0);
    check_val("rst_bus", 128'(mc_data), 128'(16'hFFFF));
    reset = 1'b1;
    repeat (4) @(negedge clock);

    bus_write(6'h19, 16'h0003);
    bus_write(6'h1A, 16'h0003);
    check_val("cfg_pair", cfg_regs, 128'h0000_0003_0003_0000);

    cmd_ready = 1'b1;
    bus_write(6'h00, 16'h0255);
    bus_write(6'h00, 16'h0120);
    bus_write(6'h00, 16'h0202);
    bus_write(6'h00, 16'h0103);
    check_val("cmd_four", 128'(cmd_seen.size()), 128'd4);

    res_data = 16'hBEEF; res_empty = 1'b0;
    bus_read(6'h00);

    cmd_ready = 1'b0;
    bus_write(6'h00, 16'h1234);
    check_val("ovf_irq1", 128'(irq1), 128'h1);
    bus_read(6'h01);
    bus_read(6'h01);
    check_val("irq1_clear", 128'(irq1), 128'h0);

    res_empty = 1'b1;
    bus_read(6'h00);
    check_val("udf_irq1", 128'(irq1), 128'h1);
    bus_error_cycle();

    reset_mid_write();
    bus_write(6'h1A, 16'h00FF);
    check_val("fresh_1a", 128'(cfg_regs[47:32]), 128'(16'h00FF));

    for (int t = 0; t < 40; t++) begin
      cmd_ready = 1'($urandom);
      res_empty = 1'($urandom);
      res_data  = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2:    r_add = 6'h00;
        3:          r_add = 6'h01;
        4, 5, 6, 7: r_add = 6'h18 + 6'($urandom_range(0, 7));
        default:    r_add = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(2, 23))
                                                        : 6'($urandom_range(32, 63));
      endcase
      r_dat = 16'($urandom);
      if ($urandom_range(0, 1) == 0) bus_write(r_add, r_dat);
      else bus_read(r_add);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_bus_responder.md
# mc_bus_responder

FPGA-side responder for the MCU parallel bus (mc_ce/mc_we/mc_oe strobes, 6-bit mc_add, 16-bit mc_data), the other end of the MCU's bus-master transactions. It synchronizes the asynchronous active-low strobes into the `clock` domain and commits writes to a configuration register bank or a command-FIFO push port. It serves reads from the register bank, a status word, or a result-FIFO pop port, and raises irq0/irq1. It sits between the top-level MCU pins and the protocol engines and FIFOs.

## Interface
- CFG_BASE, 6'h18: first address of the 8-register config bank (0x18–0x1F).
- SYNC_STAGES, 2: synchronizer flops per strobe; minimum 2.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- mc_ce  in  1  chip enable, active low.
- mc_we  in  1  write strobe, active low.
- mc_oe  in  1  read strobe, active low.
- mc_add  in  6  word address.
- mc_data  inout  16  data bus; hi-Z unless driving a read.
- cfg_regs  out  128  flat config bank; reg n (addr CFG_BASE+n) at bits [16n+15:16n].
- cmd_data  out  16  command-FIFO push data.
- cmd_valid  out  1  one-cycle push pulse.
- cmd_ready  in  1  command FIFO can accept.
- res_data  in  16  result-FIFO head word.
- res_empty  in  1  result FIFO empty.
- res_pop  out  1  one-cycle pop pulse.
- irq0  out  1  registered ~res_empty.
- irq1  out  1  registered (overflow | underflow).

## Operation
- Address map:
  - 0x00 write: push to cmd FIFO. 0x00 read: result FIFO head, then pop.
  - 0x01 read: status {12'b0, underflow, overflow, cmd_ready, res_empty}. Writes are ignored.
  - CFG_BASE..CFG_BASE+7: read/write config registers.
  - Other addresses read 0x0000; writes to them are ignored.
- Strobes: we_s, oe_s, ce_s are the synchronized copies. A strobe is *active* when it is low and ce_s is low.
- Write cycle:
  - While we_s is active and oe_s is inactive, mc_add and mc_data are latched every cycle.
  - On the we_s deassert edge (low→high), the write commits using the last latched address/data.
  - Config write: the register updates at the next edge.
  - 0x00 write: cmd_data ← latched data. If cmd_ready=1 at the commit cycle, cmd_valid pulses for 1 cycle. Otherwise the word is dropped and overflow is set (sticky).
- Read cycle:
  - On the oe_s assert edge (high→low), with we_s inactive, the read word is captured from the address map and held in rd_reg.
  - mc_data drives rd_reg while oe_s is active and we_s is inactive.
  - 0x00 read with res_empty=1: returns 0x0000, sets underflow (sticky), no pop.
  - On the oe_s deassert edge after a 0x00 read with res_empty=0 at capture, res_pop pulses for 1 cycle.
  - On the oe_s deassert edge after a 0x01 read, overflow and underflow clear. A flag set in that same cycle wins.
- Both we_s and oe_s active at once: protocol error. The bus is not driven, no commit occurs, and no capture occurs. Edge tracking continues.
- Strobe edges with ce_s high are ignored.
- Reset (reset=0 at a clock edge):
  - cfg_regs=0, cmd_valid=0, res_pop=0, irq0=0, irq1=0, flags=0, rd_reg=0, mc_data hi-Z.
  - Synchronizer and edge history are forced to "deasserted". A strobe held low through reset release produces no edge until it returns high and then deasserts; an in-flight transaction is aborted, not committed.

## Timing
- Input synchronization latency: SYNC_STAGES cycles; edge detection adds 1 cycle.
- Write: cmd_valid / config update appears SYNC_STAGES+1 cycles after the raw mc_we rising edge.
- Read: mc_data is valid SYNC_STAGES+1 cycles after raw mc_oe falls. The MCU waits ≥4 clocks before sampling.
- Bus release: mc_data goes hi-Z SYNC_STAGES cycles after raw mc_oe rises.
- res_pop: SYNC_STAGES+1 cycles after raw mc_oe rises.
- irq0 and irq1 are registered: 1 cycle after their source changes.
- The MCU holds mc_add/mc_data stable for the whole strobe-low period. Minimum strobe low and high time is SYNC_STAGES+2 clocks.

## Test plan
- Write 0x19=0x0003, then 0x1A=0x0003, with 6-clock strobes → cfg_regs[31:16]=0x0003 and [47:32]=0x0003; all other bits 0.
- cmd_ready=1; write 0x00 with 0x0255, 0x0120, 0x0202, 0x0103 → exactly four cmd_valid pulses, with cmd_data matching in order.
- res_data=0xBEEF, res_empty=0; read 0x00 → mc_data=0xBEEF while mc_oe low; one res_pop after release; bus hi-Z afterwards.
- cmd_ready=0; write 0x00 with 0x1234 → no cmd_valid, irq1=1, status read=0x0004. A second status read returns 0x0000 with res_empty=0 and cmd_ready=0, and irq1 drops.
- res_empty=1; read 0x00 → 0x0000, no res_pop, underflow and irq1 set. mc_we and mc_oe low together → no drive, no commit.
- reset=0 with mc_we low mid-write to 0x1A (data 0x00FF) → reg stays 0x0000, and no commit after reset release until a fresh strobe.
